// File: rtl/sub_nbit_serial.sv
// ---------------------------------------------------------------------------
// sub_nbit_serial
//   Bit-serial unsigned subtractor, diff = a - b, one bit per clock, LSB first.
//   Result is N+1 bits two's complement; diff[N] is the final borrow.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; diff holds the last result
//   SHIFT | one operand bit pair consumed per cycle, N cycles total
//   DONE  | one-cycle done pulse; start here begins the next operation
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted in IDLE or DONE only
//   a, b   N-bit unsigned operands, sampled on the accepting edge
//   busy   high while SHIFT is active (registered)
//   done   single-cycle pulse when diff is updated (registered)
//   diff   N+1-bit two's complement result, held until the next DONE
// ---------------------------------------------------------------------------
module sub_nbit_serial #(
   parameter int N = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N:0]   diff
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [N-1:0]    sh_a, sh_b, acc, acc_n, d_vec;
   logic [CW-1:0]   cnt;
   logic            br, br_n, d, load, last;

   // one full-subtractor slice plus the result shift
   always_comb begin
      d        = sh_a[0] ^ sh_b[0] ^ br;
      br_n     = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
      d_vec    = '0;
      d_vec[N-1] = d;
      // new bit enters at the MSB; after N shifts bit 0 is the first result bit
      acc_n    = (acc >> 1) | d_vec;
      last     = (cnt == LAST);
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (last) state_n = DONE;
         end
         DONE: begin
            if (start) begin
               load    = 1'b1;
               state_n = SHIFT;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sh_a  <= '0;
         sh_b  <= '0;
         acc   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         // outputs follow the next state so they are plain flops
         busy  <= (state_n == SHIFT);
         done  <= (state_n == DONE);
         if (load) begin
            sh_a <= a;
            sh_b <= b;
            acc  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
         end else if (state == SHIFT) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            acc  <= acc_n;
            br   <= br_n;
            cnt  <= cnt + 1'b1;
            if (last) diff <= {br_n, acc_n};
         end
      end
   end

endmodule

// File: tb/tb_sub_nbit_serial.sv
module tb_sub_nbit_serial;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance, N = 10
   logic        start10 = 1'b0;
   logic [9:0]  a10 = '0, b10 = '0;
   logic        busy10, done10;
   logic [10:0] diff10;

   // sweep instances
   logic        start1 = 1'b0;
   logic [0:0]  a1 = '0, b1 = '0;
   logic        busy1, done1;
   logic [1:0]  diff1;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [16:0] diff16;

   sub_nbit_serial #(.N(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .start(start10), .a(a10), .b(b10),
      .busy(busy10), .done(done10), .diff(diff10));

   sub_nbit_serial #(.N(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1));

   sub_nbit_serial #(.N(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .diff(diff16));

   int checks = 0;
   int passed = 0;

   logic [10:0] q10[$];
   logic [1:0]  q1[$];
   logic [16:0] q16[$];
   logic [10:0] last_diff10 = '0;

   // Drives one N=10 operation from the current cycle, then compares diff,
   // latency, busy length and that diff stayed unchanged while busy.
   // Returns in the DONE cycle (sampled 1 time unit after the edge).
   task automatic do_op10(input logic [9:0] aa, input logic [9:0] bb, input string nm);
      int edges = 0;
      int busyc = 0;
      bit held  = 1'b1;
      bit both  = 1'b0;
      logic [10:0] exp;
      q10.push_back(11'(aa) - 11'(bb));
      a10 = aa; b10 = bb; start10 = 1'b1;
      @(posedge clk); #1;
      start10 = 1'b0;
      a10 = ~aa; b10 = ~bb;             // operands may change while busy
      while (!done10 && edges < 50) begin
         if (busy10) busyc++;
         if (busy10 && diff10 !== last_diff10) held = 1'b0;
         @(posedge clk); #1;
         edges++;
      end
      if (busy10 && done10) both = 1'b1;
      exp = q10.pop_front();
      checks++;
      if (done10 !== 1'b1) $display("FAIL %s_done: timeout after %0d edges", nm, edges);
      else passed++;
      checks++;
      if (diff10 !== exp) $display("FAIL %s_diff: got %h want %h", nm, diff10, exp);
      else passed++;
      checks++;
      if (edges != 10) $display("FAIL %s_latency: got %0d edges want 10", nm, edges);
      else passed++;
      checks++;
      if (busyc != 10 || both) $display("FAIL %s_busy: got %0d busy cycles (overlap=%0d) want 10 (0)", nm, busyc, both);
      else passed++;
      checks++;
      if (!held) $display("FAIL %s_held: diff changed during SHIFT, want %h", nm, last_diff10);
      else passed++;
      last_diff10 = exp;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy10 !== 1'b0 || done10 !== 1'b0 || diff10 !== 11'd0)
         $display("FAIL reset: busy=%b done=%b diff=%h want 0 0 000", busy10, done10, diff10);
      else passed++;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy10 !== 1'b0 || done10 !== 1'b0)
         $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy10, done10);
      else passed++;
   endtask

   task automatic test_basic();
      do_op10(10'd0, 10'd0, "zero");
      @(posedge clk); #1;
      do_op10(10'd99, 10'd1, "pos");
      @(posedge clk); #1;
      do_op10(10'd1, 10'd99, "neg");
      @(posedge clk); #1;
      do_op10(10'd0, 10'd1023, "min");
      @(posedge clk); #1;
      do_op10(10'd1023, 10'd0, "max");
      @(posedge clk); #1;
      checks++;
      if (done10 !== 1'b0 || diff10 !== 11'h3FF)
         $display("FAIL idle_hold: done=%b diff=%h want 0 3ff", done10, diff10);
      else passed++;
   endtask

   task automatic test_ignore_start();
      int edges = 0;
      int dones = 0;
      logic [10:0] exp;
      q10.push_back(11'd33);
      a10 = 10'd66; b10 = 10'd33; start10 = 1'b1;
      @(posedge clk); #1;
      start10 = 1'b0;
      while (!done10 && edges < 50) begin
         if (edges == 3) begin
            a10 = 10'd5; b10 = 10'd7; start10 = 1'b1;
         end else begin
            start10 = 1'b0;
         end
         @(posedge clk); #1;
         edges++;
         if (done10) dones++;
      end
      start10 = 1'b0;
      exp = q10.pop_front();
      checks++;
      if (dones != 1 || edges != 10)
         $display("FAIL ignore_timing: done after %0d edges (pulses %0d) want 10 (1)", edges, dones);
      else passed++;
      checks++;
      if (diff10 !== exp) $display("FAIL ignore_diff: got %h want %h", diff10, exp);
      else passed++;
      last_diff10 = exp;
   endtask

   task automatic test_back_to_back();
      // still in the DONE cycle from the previous task
      do_op10(10'd47, 10'd100, "b2b");
   endtask

   task automatic test_reset_midop();
      int spurious = 0;
      a10 = 10'd500; b10 = 10'd20; start10 = 1'b1;
      @(posedge clk); #1;
      start10 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy10 !== 1'b0 || done10 !== 1'b0 || diff10 !== 11'd0)
         $display("FAIL midop_reset: busy=%b done=%b diff=%h want 0 0 000", busy10, done10, diff10);
      else passed++;
      #2 rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (done10 || busy10) spurious++;
      end
      checks++;
      if (spurious != 0) $display("FAIL midop_quiet: got %0d active cycles want 0", spurious);
      else passed++;
      last_diff10 = '0;
      do_op10(10'd500, 10'd20, "after_reset");
   endtask

   task automatic test_sweep_n1();
      int bad_d = 0;
      int bad_l = 0;
      for (int i = 0; i < 1000; i++) begin
         int edges = 0;
         logic [1:0] exp;
         logic [0:0] x, y;
         x = 1'($urandom_range(0, 1));
         y = 1'($urandom_range(0, 1));
         q1.push_back(2'(x) - 2'(y));
         a1 = x; b1 = y; start1 = 1'b1;
         @(posedge clk); #1;
         start1 = 1'b0;
         while (!done1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
         end
         exp = q1.pop_front();
         if (diff1 !== exp) begin
            bad_d++;
            if (bad_d < 5) $display("FAIL n1_diff: a=%0d b=%0d got %h want %h", x, y, diff1, exp);
         end
         if (edges != 1 || done1 !== 1'b1) begin
            bad_l++;
            if (bad_l < 5) $display("FAIL n1_latency: got %0d edges want 1", edges);
         end
      end
      checks++;
      if (bad_d != 0) $display("FAIL n1_sweep_diff: got %0d errors want 0", bad_d);
      else passed++;
      checks++;
      if (bad_l != 0) $display("FAIL n1_sweep_latency: got %0d errors want 0", bad_l);
      else passed++;
   endtask

   task automatic test_sweep_n16();
      int bad_d = 0;
      int bad_l = 0;
      for (int i = 0; i < 1000; i++) begin
         int edges = 0;
         logic [16:0] exp;
         logic [15:0] x, y;
         x = 16'($urandom);
         y = 16'($urandom);
         if (i == 0) begin x = 16'h0000; y = 16'hFFFF; end
         if (i == 1) begin x = 16'hFFFF; y = 16'h0000; end
         q16.push_back(17'(x) - 17'(y));
         a16 = x; b16 = y; start16 = 1'b1;
         @(posedge clk); #1;
         start16 = 1'b0;
         while (!done16 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
         end
         exp = q16.pop_front();
         if (diff16 !== exp) begin
            bad_d++;
            if (bad_d < 5) $display("FAIL n16_diff: a=%h b=%h got %h want %h", x, y, diff16, exp);
         end
         if (edges != 16 || done16 !== 1'b1) begin
            bad_l++;
            if (bad_l < 5) $display("FAIL n16_latency: got %0d edges want 16", edges);
         end
      end
      checks++;
      if (bad_d != 0) $display("FAIL n16_sweep_diff: got %0d errors want 0", bad_d);
      else passed++;
      checks++;
      if (bad_l != 0) $display("FAIL n16_sweep_latency: got %0d errors want 0", bad_l);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_back_to_back();
      @(posedge clk); #1;
      test_reset_midop();
      @(posedge clk); #1;
      test_sweep_n1();
      test_sweep_n16();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
